spi_count_master: RTL



---
 rtl/spi_count_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/spi_count_master.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_count_pkg.sv
// Shared constants and state encoding for the counter-readout SPI initiator.
// Frame layout is {count_p, count_m}, each COUNT_W bits, MSB first on the wire.
package spi_count_pkg;

   localparam int FRAME_BITS       = 48;
   localparam int COUNT_W          = 24;
   localparam int DEF_CLK_DIV      = 6;
   localparam int DEF_CS_SETUP     = 2;
   localparam int DEF_CS_HOLD      = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCK_HI,
      SCK_LO,
      HOLD,
      GAP
   } spi_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Clears to 0 on the asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_count_master.sv
// Mode-0 SPI initiator that reads one 48-bit {count_p, count_m} frame per start.
// spi_clk/spi_cs/spi_mosi are decoded from flops only, so no input reaches them combinationally.
module spi_count_master
   import spi_count_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int CS_SETUP = DEF_CS_SETUP,
   parameter int CS_HOLD  = DEF_CS_HOLD
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] tx_data,
   output logic                  busy,
   output logic                  done,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic [COUNT_W-1:0]    count_p,
   output logic [COUNT_W-1:0]    count_m,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_cs
);

   localparam int PHASE_W = 16;
   localparam int BIT_W   = $clog2(FRAME_BITS);

   spi_state_t            state;
   spi_state_t            state_next;
   logic [PHASE_W-1:0]    phase_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] tx_shift;
   logic [FRAME_BITS-1:0] rx_shift;
   logic                  miso_sync;
   logic                  accept;
   logic                  hi_last;
   logic                  to_lo;
   logic                  frame_end;

   sync_2ff u_miso_sync (
      .clk (clk),
      .rst (rst),
      .d   (spi_miso),
      .q   (miso_sync)
   );

   assign accept    = (state == IDLE) && start;
   assign hi_last   = (state == SCK_HI) && (phase_cnt == PHASE_W'(CLK_DIV - 1));
   assign to_lo     = (state == SCK_HI) && (state_next == SCK_LO);
   assign frame_end = (state == HOLD) && (state_next == GAP);

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:   if (start) state_next = SETUP;
         SETUP:  if (phase_cnt == PHASE_W'(CS_SETUP - 1)) state_next = SCK_HI;
         SCK_HI: if (hi_last) state_next = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? HOLD : SCK_LO;
         SCK_LO: if (phase_cnt == PHASE_W'(CLK_DIV - 1)) state_next = SCK_HI;
         HOLD:   if (phase_cnt == PHASE_W'(CS_HOLD - 1)) state_next = GAP;
         GAP:    if (phase_cnt == PHASE_W'(CLK_DIV - 1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Phase counter restarts on every state change; the bit counter advances as each high phase ends.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         phase_cnt <= '0;
         bit_cnt   <= '0;
      end else begin
         state <= state_next;
         if ((state_next != state) || (state == IDLE)) begin
            phase_cnt <= '0;
         end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
         end
         if (state == IDLE) begin
            bit_cnt <= '0;
         end else if (to_lo) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end
   end

   // MISO is captured at the end of the high phase, when the responder's data has long settled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         done     <= 1'b0;
      end else begin
         if (accept) begin
            tx_shift <= tx_data;
         end else if (to_lo) begin
            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
         end
         if (accept) begin
            rx_shift <= '0;
         end else if (hi_last) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], miso_sync};
         end
         if (frame_end) begin
            rx_data <= rx_shift;
         end
         done <= frame_end;
      end
   end

   assign spi_cs   = !(state inside {SETUP, SCK_HI, SCK_LO, HOLD});
   assign spi_clk  = (state == SCK_HI);
   assign spi_mosi = !spi_cs && tx_shift[FRAME_BITS-1];
   assign busy     = (state != IDLE);
   assign count_p  = rx_data[FRAME_BITS-1 -: COUNT_W];
   assign count_m  = rx_data[COUNT_W-1:0];

endmodule
